pipeline_rr_arbiter: RTL and testbench

//  Shares one valid/ready pipeline input between NUM_REQ requester streams.
//  - Round-robin arbitration with burst locking: a granted requester keeps the port for up to MAX_BURST consecutive beats.
//  - Each beat lands in a one-entry output register tagged with its source id, which then drives the pipeline input.
//  - Sits directly in front of a pipeline instance. Tag width and burst cap bound how long one requester can stall the others.

---
 rtl/pipeline_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_pipeline_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter with burst locking that merges NUM_REQ valid/ready streams into one
// registered, id-tagged output beat feeding a downstream pipeline input.
module pipeline_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          arst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [ID_WIDTH-1:0]           data_out_id,
  output logic                          data_out_valid,
  input  logic                          data_out_ready
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_owner;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_valid;

  logic                  w_load_en;
  logic                  w_grant_found;
  logic [ID_WIDTH-1:0]   w_grant_id;
  logic [ID_WIDTH:0]     w_sum;
  logic [ID_WIDTH-1:0]   w_sel;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_sel_data;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] x);
    return (x == ID_WIDTH'(NUM_REQ - 1)) ? '0 : x + ID_WIDTH'(1);
  endfunction

  assign w_load_en = !r_valid || data_out_ready;

  // Walk the search order backwards so the earliest valid requester after r_ptr wins last.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_sum         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (ID_WIDTH + 1)'(k);
      if (w_sum >= (ID_WIDTH + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_WIDTH + 1)'(NUM_REQ);
      end
      if (req_valid_i[w_sum[ID_WIDTH-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_sum[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    w_xfer      = 1'b0;
    w_sel       = (r_state == StIdle) ? w_grant_id : r_owner;
    if (arst_n && w_load_en) begin
      w_xfer = (r_state == StIdle) ? w_grant_found : req_valid_i[r_owner];
    end
    if (w_xfer) begin
      req_ready_o[w_sel] = 1'b1;
    end
  end

  assign w_sel_data = req_data_i[w_sel * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
    end else if (w_load_en) begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_data <= w_sel_data;
        r_id   <= w_sel;
      end
      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            r_owner <= w_sel;
            r_cnt   <= CNT_WIDTH'(1);
            if (MAX_BURST == 1) begin
              r_ptr <= wrap_inc(w_sel);
            end else begin
              r_state <= StBurst;
            end
          end
        end
        StBurst: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (r_cnt + CNT_WIDTH'(1) == CNT_WIDTH'(MAX_BURST)) begin
              r_ptr   <= wrap_inc(r_owner);
              r_state <= StIdle;
            end
          end else begin
            // Owner went idle: give up the port, costing one bubble.
            r_ptr   <= wrap_inc(r_owner);
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign data_out       = r_data;
  assign data_out_id    = r_id;
  assign data_out_valid = r_valid;

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Bench for pipeline_rr_arbiter: directed vector tables plus a random run, with per-id
// scoreboard queues filled on requester handshakes and drained on output handshakes.
module tb_pipeline_rr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           arst_n;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  data_out;
  logic [1:0]     data_out_id;
  logic           data_out_valid;
  logic           data_out_ready;

  int n_run  = 0;
  int n_fail = 0;
  int seq[NR];
  logic [DW-1:0] exp_q[NR][$];
  int run_len = 0;
  int last_g  = -1;

  typedef struct {
    logic [NR-1:0] valid;
    logic          dready;
    logic [NR-1:0] exp_rdy;
    logic          exp_ov;
    logic [1:0]    exp_id;
  } vec_t;
  vec_t tbl[$];

  pipeline_rr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk_i         (clk),
    .arst_n        (arst_n),
    .req_data_i    (req_data),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .data_out      (data_out),
    .data_out_id   (data_out_id),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] beat(input int i);
    return 8'((i << 6) | (seq[i] & 63));
  endfunction

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = beat(i);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard and fairness bookkeeping before the edge, data advance after it.
  task automatic cycle();
    logic [NR-1:0] hs;
    logic [DW-1:0] e;
    int g;
    #1;
    hs = req_valid & req_ready;
    if (!arst_n) begin
      check("rdy_in_reset", 32'(req_ready), 0);
      for (int i = 0; i < NR; i++) exp_q[i].delete();
      run_len = 0;
      last_g  = -1;
    end else begin
      check("rdy_onehot0", 32'($onehot0(req_ready)), 1);
      if (data_out_valid && data_out_ready) begin
        if (exp_q[data_out_id].size() == 0) begin
          check("sb_unexpected_beat", 32'(data_out_id), 32'hFF);
        end else begin
          e = exp_q[data_out_id].pop_front();
          check("sb_data", 32'(data_out), 32'(e));
        end
      end
      g = -1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          exp_q[i].push_back(beat(i));
          g = i;
        end
      end
      if (g >= 0) begin
        if (g == last_g && run_len == MB) begin
          check("burst_cap_others_waiting", 32'(req_valid & ~hs), 0);
          run_len = 1;
        end else begin
          run_len = (g == last_g) ? run_len + 1 : 1;
        end
        last_g = g;
      end else if (!data_out_valid || data_out_ready) begin
        run_len = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) seq[i]++;
  endtask

  task automatic do_reset(input logic [NR-1:0] v);
    arst_n = 1'b0;
    req_valid = v;
    data_out_ready = 1'b1;
    repeat (2) begin
      cycle();
      check("rst_ov", 32'(data_out_valid), 0);
      check("rst_data", 32'(data_out), 0);
      check("rst_id", 32'(data_out_id), 0);
    end
    arst_n = 1'b1;
  endtask

  task automatic add(input logic [NR-1:0] v, input logic dr, input logic [NR-1:0] rdy,
                     input logic ov, input logic [1:0] id);
    vec_t t;
    t.valid = v; t.dready = dr; t.exp_rdy = rdy; t.exp_ov = ov; t.exp_id = id;
    tbl.push_back(t);
  endtask

  task automatic run_table(input string name);
    logic          prev_ov;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_id;
    foreach (tbl[k]) begin
      req_valid = tbl[k].valid;
      data_out_ready = tbl[k].dready;
      #1;
      check($sformatf("%s[%0d].ready", name, k), 32'(req_ready), 32'(tbl[k].exp_rdy));
      prev_ov = data_out_valid;
      prev_data = data_out;
      prev_id = data_out_id;
      cycle();
      check($sformatf("%s[%0d].ov", name, k), 32'(data_out_valid), 32'(tbl[k].exp_ov));
      if (tbl[k].exp_ov)
        check($sformatf("%s[%0d].id", name, k), 32'(data_out_id), 32'(tbl[k].exp_id));
      if (prev_ov && !tbl[k].dready)
        check($sformatf("%s[%0d].hold", name, k), {22'd0, data_out_id, data_out},
              {22'd0, prev_id, prev_data});
    end
    tbl.delete();
  endtask

  initial begin
    int total;
    arst_n = 1'b0;
    req_valid = '0;
    data_out_ready = 1'b1;
    for (int i = 0; i < NR; i++) seq[i] = 0;

    // Reset held with every requester asserting valid.
    do_reset(4'hF);

    // All valid, sink always ready: four-beat bursts rotate 0,1,2,3,0 with no bubble.
    for (int k = 0; k < 17; k++) add(4'hF, 1'b1, 4'(1 << ((k / 4) % 4)), 1'b1, 2'((k / 4) % 4));
    run_table("rotate");

    // Req2 bursts two beats then drops: one bubble, then req1 wins (search 3,0,1).
    do_reset(4'h0);
    add(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0);
    add(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    run_table("drop");

    // Output stalled for five clocks with everyone valid, then released.
    do_reset(4'h0);
    add(4'hF, 1'b1, 4'b0001, 1'b1, 2'd0);
    for (int k = 0; k < 5; k++) add(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0);
    for (int k = 0; k < 3; k++) add(4'hF, 1'b1, 4'b0001, 1'b1, 2'd0);
    add(4'hF, 1'b1, 4'b0010, 1'b1, 2'd1);
    run_table("stall");

    // Reset pulse in the middle of a req0 burst.
    do_reset(4'h0);
    req_valid = 4'b0001;
    data_out_ready = 1'b1;
    repeat (2) cycle();
    check("mid_pre_ov", 32'(data_out_valid), 1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 0);
    cycle();
    check("mid_rst_ov", 32'(data_out_valid), 0);
    check("mid_rst_data", 32'(data_out), 0);
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) add(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    add(4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1);
    run_table("midrst");

    // Random valids and a mostly-stalled sink.
    for (int c = 0; c < 2000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      data_out_ready = ($urandom_range(0, 5) == 0);
      cycle();
    end
    req_valid = '0;
    data_out_ready = 1'b1;
    repeat (3) cycle();
    total = 0;
    for (int i = 0; i < NR; i++) total += exp_q[i].size();
    check("drain_empty", 32'(total), 0);
    check("drain_ov", 32'(data_out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
